core_alu_issue: RTL

//  Operand-issue stage directly upstream of the RV32I ALU. Accepts decoded instructions from ID,

---
 rtl/core_alu_issue_pkg.sv | 38 +++
 rtl/core_skid_buf.sv | 125 ++++++++++++
 rtl/core_alu_issue.sv | 115 +++++++++++
 3 files changed

// File: rtl/core_alu_issue_pkg.sv
// -----------------------------------------------------------------------------
// Package: core_alu_issue_pkg
// Purpose: Shared constants for the ALU operand-issue stage.
//   - Default operand, opcode and register-index widths.
//   - ALU operation codes (one-hot, 10 bits) as seen by the RV32I ALU.
//   - Operand-select encodings used by ID_SEL_I1 / ID_SEL_I2.
// Configuration macro consumed by the top: CORE_ISSUE_FWD_EN.
// -----------------------------------------------------------------------------
package core_alu_issue_pkg;

  // Default widths of the issue datapath.
  localparam int CORE_XLEN = 32;
  localparam int CORE_OPW  = 10;
  localparam int CORE_RIDX = 5;

  // ALU operation codes. The issue stage passes these through untouched;
  // they live here so producers and the bench share one definition.
  localparam logic [CORE_OPW-1:0] ALU_CODE_SUM  = 10'h001;
  localparam logic [CORE_OPW-1:0] ALU_CODE_SUB  = 10'h002;
  localparam logic [CORE_OPW-1:0] ALU_CODE_AND  = 10'h004;
  localparam logic [CORE_OPW-1:0] ALU_CODE_OR   = 10'h008;
  localparam logic [CORE_OPW-1:0] ALU_CODE_XOR  = 10'h010;
  localparam logic [CORE_OPW-1:0] ALU_CODE_SLL  = 10'h020;
  localparam logic [CORE_OPW-1:0] ALU_CODE_SRL  = 10'h040;
  localparam logic [CORE_OPW-1:0] ALU_CODE_SRA  = 10'h080;
  localparam logic [CORE_OPW-1:0] ALU_CODE_SLT  = 10'h100;
  localparam logic [CORE_OPW-1:0] ALU_CODE_SLTU = 10'h200;

  // I1 operand source. Encoding 3 is reserved and behaves as ZERO.
  localparam logic [1:0] SEL_I1_RS1  = 2'd0;
  localparam logic [1:0] SEL_I1_PC   = 2'd1;
  localparam logic [1:0] SEL_I1_ZERO = 2'd2;

  // I2 operand source.
  localparam logic SEL_I2_RS2 = 1'b0;
  localparam logic SEL_I2_IMM = 1'b1;

endpackage : core_alu_issue_pkg

// File: rtl/core_skid_buf.sv
// -----------------------------------------------------------------------------
// Module: core_skid_buf
// Purpose: Two-entry FIFO-ordered skid buffer with valid/ready on both sides.
//   The output register drives out_data directly; the skid register catches
//   the one extra beat that can arrive while in_ready is still high after the
//   consumer stalls. in_ready is a flop, so there is no combinational path
//   from out_ready to in_ready.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   flush      in   1      drop both entries; wins over a same-cycle accept
//   in_valid   in   1      producer offers in_data
//   in_ready   out  1      registered: 1 iff the buffer is not full
//   in_data    in   WIDTH  payload from producer
//   out_valid  out  1      out_data holds a live entry
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  WIDTH  payload to consumer (reset value 0)
// -----------------------------------------------------------------------------
module core_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Occupancy states.
  localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
  localparam logic [1:0] ST_ONE   = 2'd1;  // output register valid
  localparam logic [1:0] ST_TWO   = 2'd2;  // output + skid valid

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             ready_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;

  logic accept;
  logic pop;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = ready_q;
  assign out_data  = out_q;

  // ready_q is low in TWO, so an accept can only happen in EMPTY or ONE.
  assign accept = in_valid & ready_q;
  assign pop    = out_valid & out_ready;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d            = state_q;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d          = ST_ONE;
            load_out_from_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_out_from_in = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Older entry leaves first; the skid entry moves up to the output.
          if (pop) begin
            state_d            = ST_ONE;
            load_out_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      // Registered full flag: looks at the next state, not at out_ready.
      ready_q <= (state_d != ST_TWO);
      if (load_out_from_in) begin
        out_q <= in_data;
      end else if (load_out_from_skid) begin
        out_q <= skid_q;
      end
    end
  end

  // NOTE: skid_q is a data-only register; its validity is tracked by
  // state_q, so it needs no reset and keeps the flop cheaper.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

endmodule : core_skid_buf

// File: rtl/core_alu_issue.sv
// -----------------------------------------------------------------------------
// Module: core_alu_issue
// Purpose: Operand-issue stage in front of the RV32I ALU. Captures decoded
//   instructions from ID, selects I1 (RS1/PC/ZERO) and I2 (RS2/IMM),
//   optionally forwards the writeback result into rs1/rs2, and presents a
//   registered OPCODE_ALU/ALU_I1/ALU_I2/EX_RD_IDX to the ALU through a
//   two-entry skid buffer (core_skid_buf).
// Configuration:
//   CORE_ISSUE_FWD_EN  defined   -> WB_DATA forwarded into rs1/rs2 at capture
//                      undefined -> rs1/rs2 taken from the regfile only;
//                                   WB_* ports are present but ignored.
// Ports:
//   CLK, NRST                 clock (rising edge), synchronous active-low reset
//   FLUSH                     drop all held instructions
//   ID_VALID / ID_READY       ID-side handshake (ID_READY is registered)
//   ID_OPCODE_ALU [OPW]       ALU operation code, passed through unmodified
//   ID_SEL_I1 [2], ID_SEL_I2  operand source selects
//   ID_RS1_IDX, ID_RS2_IDX    source register indices
//   ID_RS1_DATA, ID_RS2_DATA  regfile read data
//   ID_PC, ID_IMM             instruction PC, sign-extended immediate
//   ID_RD_IDX                 destination index, carried to EX_RD_IDX
//   WB_WE, WB_RD_IDX, WB_DATA writeback port used for forwarding
//   EX_VALID / EX_READY       EX-side handshake
//   OPCODE_ALU, ALU_I1, ALU_I2, EX_RD_IDX  registered outputs to the ALU
// -----------------------------------------------------------------------------
module core_alu_issue
  import core_alu_issue_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int OPW  = CORE_OPW,
  parameter int RIDX = CORE_RIDX
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            FLUSH,
  input  logic            ID_VALID,
  output logic            ID_READY,
  input  logic [OPW-1:0]  ID_OPCODE_ALU,
  input  logic [1:0]      ID_SEL_I1,
  input  logic            ID_SEL_I2,
  input  logic [RIDX-1:0] ID_RS1_IDX,
  input  logic [RIDX-1:0] ID_RS2_IDX,
  input  logic [XLEN-1:0] ID_RS1_DATA,
  input  logic [XLEN-1:0] ID_RS2_DATA,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [RIDX-1:0] ID_RD_IDX,
  input  logic            WB_WE,
  input  logic [RIDX-1:0] WB_RD_IDX,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            EX_VALID,
  input  logic            EX_READY,
  output logic [OPW-1:0]  OPCODE_ALU,
  output logic [XLEN-1:0] ALU_I1,
  output logic [XLEN-1:0] ALU_I2,
  output logic [RIDX-1:0] EX_RD_IDX
);

  localparam int PW = OPW + 2 * XLEN + RIDX;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] i1_val;
  logic [XLEN-1:0] i2_val;
  logic [PW-1:0]   in_payload;
  logic [PW-1:0]   out_payload;

`ifdef CORE_ISSUE_FWD_EN
  // Forwarding is applied only when the instruction is captured; entries
  // already held do not snoop later writebacks. x0 is never forwarded.
  logic fwd_rs1;
  logic fwd_rs2;

  assign fwd_rs1 = WB_WE && (WB_RD_IDX != '0) && (WB_RD_IDX == ID_RS1_IDX);
  assign fwd_rs2 = WB_WE && (WB_RD_IDX != '0) && (WB_RD_IDX == ID_RS2_IDX);
  assign rs1_val = fwd_rs1 ? WB_DATA : ID_RS1_DATA;
  assign rs2_val = fwd_rs2 ? WB_DATA : ID_RS2_DATA;
`else
  // Writeback and index inputs have no consumer in this build.
  logic unused_fwd_inputs;

  assign unused_fwd_inputs = ^{WB_WE, WB_RD_IDX, WB_DATA, ID_RS1_IDX, ID_RS2_IDX};
  assign rs1_val           = ID_RS1_DATA;
  assign rs2_val           = ID_RS2_DATA;
`endif

  // Reserved I1 encoding behaves as ZERO.
  always_comb begin
    case (ID_SEL_I1)
      SEL_I1_RS1: i1_val = rs1_val;
      SEL_I1_PC:  i1_val = ID_PC;
      default:    i1_val = '0;
    endcase
  end

  assign i2_val = (ID_SEL_I2 == SEL_I2_IMM) ? ID_IMM : rs2_val;

  assign in_payload = {ID_OPCODE_ALU, i1_val, i2_val, ID_RD_IDX};
  assign {OPCODE_ALU, ALU_I1, ALU_I2, EX_RD_IDX} = out_payload;

  core_skid_buf #(
    .WIDTH (PW)
  ) u_skid_buf (
    .clk       (CLK),
    .rst_n     (NRST),
    .flush     (FLUSH),
    .in_valid  (ID_VALID),
    .in_ready  (ID_READY),
    .in_data   (in_payload),
    .out_valid (EX_VALID),
    .out_ready (EX_READY),
    .out_data  (out_payload)
  );

endmodule : core_alu_issue
